imem_loader: RTL and testbench

- Boot-time writer for the instruction memory port that the core only reads.
- Accepts a framed byte stream over a valid/ready handshake, assembles bytes into instruction words and writes them into instruction memory.
- Holds the core stalled via cpu_hold until a frame is fully received and its checksum verifies, then releases it.
- Sits between the off-chip byte source and the instruction memory write port, beside the mips8 top.

---
 rtl/imem_loader.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. Receives a framed byte stream
// over a valid/ready handshake, packs the bytes into instruction words (MSB
// byte first) and writes each word into instruction memory. The core is held
// off via cpu_hold until a whole frame has arrived and its checksum is good.
//
// Frame: SYNC_BYTE, LEN (word count, 0 = 2^ADDR_W words),
//        LEN*INSTR_BYTES data bytes, CSUM.
// A frame is good when the 8-bit sum of all data bytes plus CSUM is 8'h00.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   in_data   in   [7:0] stream byte
//   in_valid  in   in_data valid this cycle
//   in_ready  out  loader accepts a byte (transfer = in_valid && in_ready)
//   im_wen    out  one-cycle instruction memory write strobe
//   im_addr   out  [ADDR_W-1:0] instruction memory write address
//   im_wdata  out  [8*INSTR_BYTES-1:0] instruction memory write data
//   cpu_hold  out  high keeps the core stalled
//   done      out  last frame loaded with a good checksum
//   error     out  last frame failed; sticky until the next SYNC_BYTE
//
// Build option:
//   LOADER_TIMEOUT_EN  when defined, a frame that sees no accepted byte for
//                      TIMEOUT_CYC cycles while in LEN/DATA/CSUM is aborted
//                      into ERR. When undefined, a stalled frame waits
//                      forever.
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int         ADDR_W      = 8,
    parameter int         INSTR_BYTES = 2,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       im_wen,
    output logic [ADDR_W-1:0]          im_addr,
    output logic [8*INSTR_BYTES-1:0]   im_wdata,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       error
);

    localparam int WORD_W = 8 * INSTR_BYTES;
    // Word counter must hold 2^ADDR_W (LEN=0) and any 8-bit LEN value.
    localparam int CNT_W  = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam int BC_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t             state_q,    state_d;
    logic [7:0]         len_q,      len_d;
    logic [WORD_W-1:0]  word_q,     word_d;
    logic [7:0]         sum_q,      sum_d;
    logic [BC_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic               im_wen_q,   im_wen_d;
    logic [ADDR_W-1:0]  im_addr_q,  im_addr_d;
    logic [WORD_W-1:0]  im_wdata_q, im_wdata_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q,     done_d;
    logic               error_q,    error_d;

    logic               accept;
    logic               is_sync;
    logic [WORD_W-1:0]  shifted_word;
    logic [7:0]         sum_next;
    logic [CNT_W-1:0]   total_words;
    logic               byte_last;
    logic               word_last;
    logic               timeout_hit;

    // The only state that refuses bytes is the one-cycle ERR state; reset
    // also drops ready so nothing is taken while the loader is being cleared.
    assign in_ready = (state_q != ERR) && !reset;
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);

    // New byte enters at the bottom so the first byte ends up in the MSBs.
    assign shifted_word = (word_q << 8) | WORD_W'(in_data);
    assign sum_next     = sum_q + in_data;

    // LEN=0 encodes a full memory image.
    assign total_words = (len_q == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(len_q);
    assign byte_last   = (byte_cnt_q == BC_W'(INSTR_BYTES - 1));
    assign word_last   = ((word_cnt_q + CNT_W'(1)) == total_words);

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
    logic               to_active;

    // The counter only runs while a frame is in flight; any accepted byte
    // restarts the window.
    assign to_active   = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    assign timeout_hit = to_active && !accept && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_active && !accept && !timeout_hit) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end
`else
    // No timeout in this build; TIMEOUT_CYC only shapes the optional counter.
    assign timeout_hit = 1'b0;
    if (TIMEOUT_CYC < 1) begin : g_timeout_range
    end
`endif

    // Next-state and next-output logic for the whole loader. All outputs are
    // registered, so every flag change becomes visible the cycle after the
    // byte that caused it.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        sum_d      = sum_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        im_wen_d   = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            IDLE, DONE: begin
                // Both wait for a sync byte and anything else is dropped.
                // Starting a load stalls the core again and clears the
                // status of the previous frame.
                if (accept && is_sync) begin
                    state_d    = LEN;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    sum_d      = '0;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    word_idx_d = '0;
                end
            end

            LEN: begin
                if (accept) begin
                    len_d   = in_data;
                    state_d = DATA;
                end
            end

            DATA: begin
                if (accept) begin
                    sum_d  = sum_next;
                    word_d = shifted_word;
                    if (byte_last) begin
                        // Word complete: present it on the write port next
                        // cycle and move on to the following address.
                        byte_cnt_d = '0;
                        im_wen_d   = 1'b1;
                        im_addr_d  = word_idx_q;
                        im_wdata_d = shifted_word;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        if (word_last) begin
                            state_d = CSUM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end

            CSUM: begin
                if (accept) begin
                    if (sum_next == 8'h00) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end

            ERR: begin
                // Words already written stay in memory; cpu_hold remaining
                // high is what keeps the core away from them.
                state_d    = IDLE;
                cpu_hold_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled frame is abandoned. No byte was accepted this cycle, so
        // there is no write to conflict with.
        if (timeout_hit) begin
            state_d    = ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
            done_d     = 1'b0;
        end
    end

    // Single register stage for state, datapath and outputs. Reset wins over
    // everything, including a write strobe that was due next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            im_wen_q   <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            im_wen_q   <= im_wen_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Inactivity counter for the optional frame timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign im_wen   = im_wen_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed frames are pushed into the loader one byte at a time; for every
// word a frame should write, the expected {addr, data} pair is queued before
// the frame is sent. A free-running monitor pops that queue on each write
// strobe and compares. Status flags are checked directly at frame boundaries.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int IB     = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           in_data = 8'h00;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 im_wen;
    logic [ADDR_W-1:0]    im_addr;
    logic [8*IB-1:0]      im_wdata;
    logic                 cpu_hold;
    logic                 done;
    logic                 error;

    int                   nvec = 0;
    int                   nfail = 0;
    logic [23:0]          exp_q[$];
    logic [7:0]           frame_q[$];
    logic                 prev_wen = 1'b0;

    imem_loader #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (IB),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_wen   (im_wen),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nvec++;
        if (actual !== expected) begin
            nfail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer one byte, wait (bounded) for it to be taken, then idle 'gap'
    // cycles. Returns 1 time unit after the accepting clock edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            nvec++;
            nfail++;
            $display("[TB] FAIL ready_wait: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input int gap);
        foreach (frame_q[i]) applyStimulus(frame_q[i], gap);
    endtask

    task automatic checkFlags(input string tag, input logic exp_done,
                              input logic exp_hold, input logic exp_err);
        checkOutput({tag, "_done"},     32'(done),     32'(exp_done));
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_hold));
        checkOutput({tag, "_error"},    32'(error),    32'(exp_err));
    endtask

    // Monitor: every write strobe must match the next queued expectation and
    // strobes must never appear on consecutive cycles.
    always @(negedge clk) begin
        logic [23:0] item;
        if (!reset && im_wen === 1'b1) begin
            checkOutput("wen_not_back_to_back", 32'(prev_wen), 32'd0);
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("[TB] FAIL unexpected_write: addr=%0h data=%0h, expected no write",
                         im_addr, im_wdata);
            end else begin
                item = exp_q.pop_front();
                checkOutput("write_addr", 32'(im_addr),  32'(item[23:16]));
                checkOutput("write_data", 32'(im_wdata), 32'(item[15:0]));
            end
        end
        prev_wen = reset ? 1'b0 : im_wen;
    end

    // Global watchdog so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] imem_loader bench start");

        // Reset held: all outputs at reset values.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_im_wen",   32'(im_wen),   32'd0);
        checkOutput("rst_im_addr",  32'(im_addr),  32'd0);
        checkOutput("rst_im_wdata", 32'(im_wdata), 32'd0);
        checkFlags("rst", 1'b0, 1'b1, 1'b0);

        // Release reset, no input.
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkFlags("no_input", 1'b0, 1'b1, 1'b0);

        // Good frame with a leading junk byte, continuous valid.
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'h5678});
        frame_q = '{8'h3C, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
        sendFrame(0);
        checkFlags("good", 1'b1, 1'b0, 1'b0);

        // Reload after a good load: hold reasserts right after the sync byte.
        applyStimulus(8'hA5, 0);
        checkFlags("restart_sync", 1'b0, 1'b1, 1'b0);
        exp_q.push_back({8'h00, 16'hABCD});
        frame_q = '{8'h01, 8'hAB, 8'hCD, 8'h88};
        sendFrame(0);
        checkFlags("restart_done", 1'b1, 1'b0, 1'b0);

        // Bad checksum: writes still happen, then one ERR cycle.
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'h5678});
        frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hED};
        sendFrame(0);
        checkFlags("bad", 1'b0, 1'b1, 1'b1);
        checkOutput("bad_err_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(8'h00, 0);
        checkFlags("bad_idle_byte", 1'b0, 1'b1, 1'b1);

        // Good frame with an idle cycle between every byte.
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'h5678});
        frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
        sendFrame(1);
        checkFlags("gapped", 1'b1, 1'b0, 1'b0);
        checkOutput("gapped_last_addr", 32'(im_addr),  32'h01);
        checkOutput("gapped_last_data", 32'(im_wdata), 32'h5678);

        // Reset in the middle of a frame.
        frame_q = '{8'hA5, 8'h02, 8'h12};
        sendFrame(0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_im_wen",   32'(im_wen),   32'd0);
        checkOutput("midrst_im_addr",  32'(im_addr),  32'd0);
        checkOutput("midrst_im_wdata", 32'(im_wdata), 32'd0);
        checkFlags("midrst", 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // A fresh frame after the aborted one assembles cleanly.
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'h5678});
        frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEC};
        sendFrame(0);
        checkFlags("after_rst", 1'b1, 1'b0, 1'b0);

`ifdef LOADER_TIMEOUT_EN
        // Stall after the first data byte; ERR fires 16 cycles later.
        frame_q = '{8'hA5, 8'h02, 8'h12};
        sendFrame(0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("timeout_early_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        checkFlags("timeout", 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
